// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction fetch unit.
// The fetch FIFO stores one fetch_entry_t per returned instruction.
package ifu_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [INST_W-1:0] INST_NOP  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam int FIFO_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO with flush. Depth must be a power of two.
// Push and pop in the same cycle are accepted even when full.
module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop))
        else $error("ifu_fifo: push while full");

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: prefetches words over a request/grant/rvalid bus into
// a small FIFO and presents them to decode, honouring jumps and stalls.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_flag_i,
    output logic              ibus_req_o,
    output logic [ADDR_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [INST_W-1:0] ibus_rdata_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o
);

    localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int              DISC_W  = 8;
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [DISC_W-1:0] discard;
    logic              fifo_full;
    logic              fifo_empty;
    logic              grant;
    logic              push;
    logic              pop;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;
    logic [$bits(fetch_entry_t)-1:0] fifo_rdata;

    // Bus handshake: a request transfers on any cycle where ibus_req_o and
    // ibus_gnt_i are both high; ibus_rvalid_i is always accepted, returns
    // responses in grant order, and arrives at least one cycle after its grant.
    assign ibus_req_o  = rst && !jump_flag_i && !fifo_full &&
                         (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_L);
    assign ibus_addr_o = fetch_pc;
    assign grant       = ibus_req_o && ibus_gnt_i;

    // Responses in the jump cycle or owed to pre-jump requests are dropped.
    assign push = ibus_rvalid_i && !jump_flag_i && (discard == '0);
    assign pop  = !hold_flag_i && !jump_flag_i && !fifo_empty;

    assign wr_entry = '{inst: ibus_rdata_i, addr: resp_pc};
    assign head     = fifo_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= word_align(RESET_PC);
            resp_pc     <= word_align(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
        end else if (jump_flag_i) begin
            fetch_pc    <= word_align(jump_addr_i);
            resp_pc     <= word_align(jump_addr_i);
            outstanding <= '0;
            // Every in-flight response is now stale; one may be landing right now.
            discard     <= discard + DISC_W'(outstanding) - DISC_W'(ibus_rvalid_i);
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (push)  resp_pc  <= resp_pc + 32'd4;
            if (ibus_rvalid_i && (discard != '0)) discard <= discard - DISC_W'(1);
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(push);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_o       <= INST_NOP;
            inst_addr_o  <= ZERO_WORD;
            inst_valid_o <= 1'b0;
        end else if (!hold_flag_i) begin
            if (!jump_flag_i && !fifo_empty) begin
                inst_o       <= head.inst;
                inst_addr_o  <= head.addr;
                inst_valid_o <= 1'b1;
            end else begin
                inst_o       <= INST_NOP;
                inst_addr_o  <= ZERO_WORD;
                inst_valid_o <= 1'b0;
            end
        end
    end

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (jump_flag_i),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: a behavioural instruction bus returns word == address,
// and each task checks the decode-side stream against hand-derived values.
module tb_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_i = 1'b0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t rsp_q[$];
  int gnt_pct = 100;
  int lat_min = 1;
  int lat_max = 1;

  ifu #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .hold_flag_i   (hold_flag_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus responder: in-order responses, data == address, latency lat_min..lat_max.
  initial begin : bus_model
    forever begin
      @(negedge clk);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cycle) begin
        ibus_rvalid_i = 1'b1;
        ibus_rdata_i  = rsp_q[0].addr;
        void'(rsp_q.pop_front());
      end else begin
        ibus_rvalid_i = 1'b0;
        ibus_rdata_i  = 32'hDEAD_BEEF;
      end
      ibus_gnt_i = (int'($urandom_range(99, 0)) < gnt_pct);
      #1;
      if (rst && ibus_req_o && ibus_gnt_i)
        rsp_q.push_back('{addr: ibus_addr_o, due: cycle + int'($urandom_range(lat_max, lat_min))});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int pct, input int lmin, input int lmax);
    rst = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    hold_flag_i = 1'b0;
    gnt_pct = pct;
    lat_min = lmin;
    lat_max = lmax;
    repeat (2) tick();
    rsp_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (inst_valid_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h40;
    #1 rst = 1'b0;
    repeat (2) tick();
    jump_flag_i = 1'b0;
    #1;
    tests_run++;
    if (inst_o !== NOP) begin tests_failed++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    tests_run++;
    if (inst_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_addr: got %h want 0", inst_addr_o); end
    tests_run++;
    if (inst_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
    tests_run++;
    if (ibus_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", ibus_req_o); end
    tests_run++;
    if (ibus_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h want 0", ibus_addr_o); end
    // Run a few cycles, then reset in the middle of traffic.
    rsp_q.delete();
    rst = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (inst_valid_o !== 1'b1 || inst_o !== 32'h0 || inst_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL pre_midreset: got valid=%b inst=%h addr=%h want 1/0/0", inst_valid_o, inst_o, inst_addr_o);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || ibus_req_o !== 1'b0 || ibus_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL midreset: got valid=%b inst=%h req=%b pc=%h want 0/%h/0/0",
               inst_valid_o, inst_o, ibus_req_o, ibus_addr_o, NOP);
    end
  endtask

  task automatic test_sequential();
    int exp_tab [10] = '{-1, -1, 0, 4, -1, 8, 12, -1, 16, 20};
    do_reset(100, 1, 1);
    #1;
    tests_run++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL first_req: got req=%b addr=%h want 1/0", ibus_req_o, ibus_addr_o);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (exp_tab[k] < 0) begin
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
          tests_failed++;
          $display("FAIL seq_edge%0d: got valid=%b inst=%h addr=%h want NOP", k + 1, inst_valid_o, inst_o, inst_addr_o);
        end
      end else if (inst_valid_o !== 1'b1 || inst_o !== 32'(exp_tab[k]) || inst_addr_o !== 32'(exp_tab[k])) begin
        tests_failed++;
        $display("FAIL seq_edge%0d: got valid=%b inst=%h addr=%h want valid inst/addr %h",
                 k + 1, inst_valid_o, inst_o, inst_addr_o, 32'(exp_tab[k]));
      end
    end
  endtask

  task automatic test_hold();
    bit seen;
    do_reset(100, 1, 1);
    repeat (4) tick();
    hold_flag_i = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      tick();
      tests_run++;
      if (inst_valid_o !== 1'b1 || inst_o !== 32'h4 || inst_addr_o !== 32'h4) begin
        tests_failed++;
        $display("FAIL hold_freeze_edge%0d: got valid=%b inst=%h addr=%h want 1/4/4", k, inst_valid_o, inst_o, inst_addr_o);
      end
      if (k >= 6) begin
        tests_run++;
        if (ibus_req_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL hold_req_edge%0d: got %b want 0", k, ibus_req_o);
        end
      end
    end
    hold_flag_i = 1'b0;
    for (int a = 8; a <= 20; a += 4) begin
      wait_valid(10, seen);
      tests_run++;
      if (!seen || inst_o !== 32'(a) || inst_addr_o !== 32'(a)) begin
        tests_failed++;
        $display("FAIL hold_release: seen=%b inst=%h addr=%h want %h", seen, inst_o, inst_addr_o, 32'(a));
      end
    end
  endtask

  task automatic test_jump_outstanding();
    bit seen;
    do_reset(100, 3, 3);
    repeat (2) tick();
    tests_run++;
    if (ibus_req_o !== 1'b0) begin tests_failed++; $display("FAIL two_outstanding_req: got %b want 0", ibus_req_o); end
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    tick();
    jump_flag_i = 1'b0;
    #1;
    tests_run++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL jump_nop: got valid=%b inst=%h addr=%h want NOP", inst_valid_o, inst_o, inst_addr_o);
    end
    tests_run++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL jump_target_req: got req=%b addr=%h want 1/100", ibus_req_o, ibus_addr_o);
    end
    for (int a = 32'h100; a <= 32'h104; a += 4) begin
      wait_valid(20, seen);
      tests_run++;
      if (!seen || inst_o !== 32'(a) || inst_addr_o !== 32'(a)) begin
        tests_failed++;
        $display("FAIL jump_discard: seen=%b inst=%h addr=%h want %h", seen, inst_o, inst_addr_o, 32'(a));
      end
    end
  endtask

  task automatic test_jump_unaligned();
    bit seen;
    do_reset(100, 1, 1);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h103;
    #1;
    tests_run++;
    if (ibus_req_o !== 1'b0) begin tests_failed++; $display("FAIL jump_cycle_req: got %b want 0", ibus_req_o); end
    tick();
    jump_flag_i = 1'b0;
    #1;
    tests_run++;
    if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL unaligned_pc: got req=%b addr=%h want 1/100", ibus_req_o, ibus_addr_o);
    end
    wait_valid(20, seen);
    tests_run++;
    if (!seen || inst_o !== 32'h100 || inst_addr_o !== 32'h100) begin
      tests_failed++;
      $display("FAIL unaligned_inst: seen=%b inst=%h addr=%h want 100", seen, inst_o, inst_addr_o);
    end
  endtask

  task automatic test_jump_rvalid();
    bit seen;
    do_reset(100, 1, 1);
    tick();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h200;
    tick();
    jump_flag_i = 1'b0;
    tests_run++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL jump_rvalid_nop: got valid=%b inst=%h addr=%h want NOP", inst_valid_o, inst_o, inst_addr_o);
    end
    for (int a = 32'h200; a <= 32'h204; a += 4) begin
      wait_valid(20, seen);
      tests_run++;
      if (!seen || inst_o !== 32'(a) || inst_addr_o !== 32'(a)) begin
        tests_failed++;
        $display("FAIL jump_rvalid_drop: seen=%b inst=%h addr=%h want %h", seen, inst_o, inst_addr_o, 32'(a));
      end
    end
  endtask

  task automatic test_jump_flush();
    bit seen;
    do_reset(100, 1, 1);
    repeat (4) tick();
    hold_flag_i = 1'b1;
    repeat (3) tick();
    hold_flag_i = 1'b0;
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h300;
    tick();
    jump_flag_i = 1'b0;
    tests_run++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
      tests_failed++;
      $display("FAIL flush_nop: got valid=%b inst=%h want NOP", inst_valid_o, inst_o);
    end
    wait_valid(20, seen);
    tests_run++;
    if (!seen || inst_o !== 32'h300 || inst_addr_o !== 32'h300) begin
      tests_failed++;
      $display("FAIL flush_next: seen=%b inst=%h addr=%h want 300", seen, inst_o, inst_addr_o);
    end
  endtask

  task automatic test_wrap();
    bit seen;
    logic [31:0] a;
    do_reset(100, 1, 1);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFF8;
    tick();
    jump_flag_i = 1'b0;
    a = 32'hFFFF_FFF8;
    for (int n = 0; n < 4; n++) begin
      wait_valid(20, seen);
      tests_run++;
      if (!seen || inst_o !== a || inst_addr_o !== a) begin
        tests_failed++;
        $display("FAIL wrap_%0d: seen=%b inst=%h addr=%h want %h", n, seen, inst_o, inst_addr_o, a);
      end
      a = a + 32'd4;
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] exp_addr;
    int got;
    bit held;
    bit bad;
    do_reset(75, 1, 3);
    exp_addr = 32'h0;
    got = 0;
    bad = 1'b0;
    for (int i = 0; i < 60000 && got < 10000 && !bad; i++) begin
      held = (int'($urandom_range(99, 0)) < 15);
      hold_flag_i = held;
      tick();
      if (!held && inst_valid_o === 1'b1) begin
        tests_run++;
        if (inst_addr_o !== exp_addr || inst_o !== exp_addr) begin
          tests_failed++;
          bad = 1'b1;
          $display("FAIL stream_%0d: inst=%h addr=%h want %h", got, inst_o, inst_addr_o, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
        got++;
      end
    end
    hold_flag_i = 1'b0;
    tests_run++;
    if (got != 10000) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d instructions want 10000", got);
    end
  endtask

  // scoreboard sequence and final report
  initial begin : main
    test_reset();
    test_sequential();
    test_hold();
    test_jump_outstanding();
    test_jump_unaligned();
    test_jump_rvalid();
    test_jump_flush();
    test_wrap();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
